// File: rtl/roi_energy_accumulator_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// roi_energy_accumulator_if: sample stream in, window energies out. rev 1.0
// ---------------------------------------------------------------------------
interface roi_energy_accumulator_if;
  logic       start;
  logic       sample_valid;
  logic [1:0] sample_ch;
  logic [7:0] sample_data;
  logic       busy;
  logic       done;
  logic [7:0] E0;
  logic [7:0] E1;
  logic [7:0] E2;
  logic [7:0] E3;

  modport master (
    output start, sample_valid, sample_ch, sample_data,
    input  busy, done, E0, E1, E2, E3
  );

  modport slave (
    input  start, sample_valid, sample_ch, sample_data,
    output busy, done, E0, E1, E2, E3
  );
endinterface
`default_nettype wire

// File: rtl/roi_energy_accumulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// roi_energy_accumulator: per-channel windowed sums, scaled to 8 bits. rev 1.0
// ---------------------------------------------------------------------------
module roi_energy_accumulator #(
  parameter int WINDOW = 16,
  parameter int ACC_W  = 12,
  parameter int SHIFT  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  roi_energy_accumulator_if.slave  bus_if
);

  localparam int CNT_W = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0] acc_q [4];
  logic [ACC_W-1:0] acc_d [4];
  logic [7:0]       e_q   [4];
  logic [7:0]       e_d   [4];
  logic             done_q;
  logic             busy_q;
  logic             accept;

  assign accept = (state_q == S_ACCUM) && bus_if.sample_valid;

  // e_d is taken from acc_d so the closing sample is part of the final energy.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      logic [ACC_W:0]   sum;
      logic [ACC_W-1:0] scaled;
      sum      = {1'b0, acc_q[i]} + (ACC_W+1)'(bus_if.sample_data);
      acc_d[i] = acc_q[i];
      if (accept && (bus_if.sample_ch == 2'(i))) begin
        acc_d[i] = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
      end
      scaled = acc_d[i] >> SHIFT;
      e_d[i] = (scaled > ACC_W'(255)) ? 8'hFF : scaled[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= '0;
        e_q[i]   <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus_if.start) begin
            for (int i = 0; i < 4; i++) acc_q[i] <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == C_LAST) begin
              e_q     <= e_d;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_if.busy = busy_q;
  assign bus_if.done = done_q;
  assign bus_if.E0   = e_q[0];
  assign bus_if.E1   = e_q[1];
  assign bus_if.E2   = e_q[2];
  assign bus_if.E3   = e_q[3];

endmodule
`default_nettype wire

// File: doc/roi_energy_accumulator.md
# roi_energy_accumulator

Upstream stage of the ROI max encoder: integrates tagged 8-bit ADC samples from four detector channels over a fixed-length window and presents four 8-bit energies E0..E3 to the encoder. A start pulse opens a window. After WINDOW accepted samples the block scales and saturates each channel sum, registers E0..E3 and pulses done. E0..E3 hold until the next window completes.

## Interface
- WINDOW, 16: accepted samples per window, summed across all channels; legal range 2..256.
- ACC_W, 12: accumulator width per channel; must be ≥ 8.
- SHIFT, 2: right shift applied to each sum before 8-bit saturation; must satisfy SHIFT ≤ ACC_W−8.
- clk  input  1: single clock; all state updates on the rising edge.
- rst  input  1: synchronous, active-high reset.
- start  input  1: opens a window; honoured only in IDLE.
- sample_valid  input  1: sample_ch/sample_data valid this cycle.
- sample_ch  input  2: channel tag, 0..3.
- sample_data  input  8: unsigned sample.
- busy  output  1: high in ACCUM and DONE.
- done  output  1: one-cycle pulse; E0..E3 are new this cycle.
- E0, E1, E2, E3  output  8 each: registered scaled energies, channels 0..3.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 → clear acc0..acc3 and the sample counter; next state ACCUM.
  - sample_valid is ignored in IDLE, including the cycle in which start=1.
- ACCUM, on a cycle with sample_valid=1:
  - acc[sample_ch] ← sat(acc[sample_ch] + sample_data), saturating at 2^ACC_W−1. Accumulators never wrap.
  - Counter increments.
  - On the WINDOW-th accepted sample, the final sum (including that sample) is computed. Each E_i ← min(acc_i >> SHIFT, 255) is registered. Next state DONE.
- ACCUM, sample_valid=0: no change; the window has no timeout.
- start in ACCUM or DONE: ignored; it does not restart or extend the window.
- DONE: done=1 for exactly this cycle; next state IDLE unconditionally. sample_valid in DONE is ignored.
- Channels with no samples in a window produce E=0.
- E0..E3 change only on window completion. Accumulators are internal and never visible on the outputs mid-window.
- Reset values: state IDLE, counter 0, acc0..acc3 0, E0..E3 0, done 0, busy 0.
- Reset mid-window discards the partial window. The next window requires a new start.

## Timing
- start accepted in IDLE at cycle t → busy=1 from t+1. The first sample can be accepted at t+1.
- WINDOW-th valid sample at cycle s → E0..E3 updated and done=1 at s+1. busy=1 at s+1, busy=0 at s+2.
- Minimum window duration: WINDOW cycles of ACCUM plus 1 DONE cycle.
- Earliest next start: cycle s+2 (IDLE). Start-to-start spacing is therefore ≥ WINDOW+2 cycles.
- done and E0..E3 are direct register outputs with no combinational path from inputs. The ROI encoder may consume E0..E3 on the done cycle.
- rst takes effect at the next rising edge. It overrides start and sample_valid in the same cycle.

## Test plan
- Reset, then start. Feed 16 samples of value 8, four per channel, interleaved 0,1,2,3 → done one cycle after the 16th sample; E0..E3 = 8 (sum 32 >> 2); busy falls the cycle after done.
- Window of 16 samples all on ch2, each 255 (sum 4080) → E2 = min(1020, 255) = 255; E0 = E1 = E3 = 0.
- ACC_W=10: 16 samples of 255 on ch1 → acc1 saturates at 1023 with no wrap; E1 = 255.
- Gaps in sample_valid plus a start pulse mid-window → window still closes on exactly the 16th valid sample; start has no effect; E values match a gap-free run with the same data.
- Assert rst after 10 samples of a window → outputs 0 and busy 0 next cycle. A following start with 16 samples of 4 on ch3 gives E3 = 16 and no carry-over from the aborted window.
- sample_valid asserted in IDLE, on the start cycle and in DONE → none of those samples is accumulated. start on the DONE cycle is ignored; start one cycle later is accepted.
